// File: rtl/mac_seq_pkg.sv
// mac_seq_pkg
//   Shared definitions for the FPMAC sequencer: the 3-bit state encoding
//   shown on the debug LEDs, and a width helper for small counters.
package mac_seq_pkg;

  // State encoding is visible on state_out, so the values are fixed.
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_INIT = 3'd1,
    ST_LOAD = 3'd2,
    ST_MAC  = 3'd3
  } state_e;

  // Bits needed to hold 0..max_val inclusive (never less than one bit).
  // The load counter uses cnt_width(LOAD_LEN), i.e. $clog2(LOAD_LEN+1).
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/blink_divider.sv
// blink_divider
//   Toggles phase_o once every DIV enabled cycles. A synchronous clear
//   returns the counter and the phase to zero; clear wins over enable.
//   The SSD controller reuses this block for its own blink.
// Ports:
//   clk     - clock
//   rst     - asynchronous active-high reset
//   clr_i   - synchronous clear of counter and phase
//   en_i    - count enable
//   phase_o - current phase, 0 for the first DIV enabled cycles after clear
module blink_divider
  import mac_seq_pkg::*;
#(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic phase_o
);

  localparam int             CW   = cnt_width(DIV);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          phase_q, phase_d;

  always_comb begin
    cnt_d   = cnt_q;
    phase_d = phase_q;
    if (clr_i) begin
      cnt_d   = '0;
      phase_d = 1'b0;
    end else if (en_i) begin
      if (cnt_q == LAST) begin
        cnt_d   = '0;
        phase_d = ~phase_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= '0;
      phase_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
    end
  end

  assign phase_o = phase_q;

endmodule

// File: rtl/mac_sequencer.sv
// mac_sequencer
//   Controller for the pipelined FPMAC system. A push-button steps through
//   IDLE -> INIT (fill SRAM) -> LOAD (SRAM to FIFO) -> MAC (FIFO to FPMAC)
//   -> IDLE. Optional continuous mode loops MAC -> LOAD on completion so
//   successive SRAM blocks are consumed without a button press.
// Ports:
//   clock, reset        - clock and asynchronous active-high reset
//   pb                  - debounced, synchronous push-button level
//   fifo_full/empty     - FIFO flags, used combinationally to gate push/pop
//   acc_count           - FPMAC accumulation count
//   mem_enable/mem_addr - SRAM control and address
//   init                - SRAM initialisation strobe
//   fifo_reset          - FIFO reset (held in IDLE)
//   fifo_write_enable   - FIFO push
//   fifo_read_enable    - FIFO pop
//   fpmac_enable        - FPMAC enable
//   ssd_rst             - SSD controller reset (held in IDLE)
//   done                - phase complete / MAC-complete blink
//   value_sel           - 0 shows SRAM data, 1 shows FPMAC result
//   state_out           - current state encoding
module mac_sequencer
  import mac_seq_pkg::*;
#(
  parameter int ADDR_W     = 4,
  parameter int MEM_DEPTH  = 16,
  parameter int LOAD_LEN   = 8,
  parameter int CNT_W      = 4,
  parameter int ACC_TARGET = 8,
  parameter int BLINK_DIV  = 4,
  parameter int CONTINUOUS = 0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              pb,
  input  logic              fifo_full,
  input  logic              fifo_empty,
  input  logic [CNT_W-1:0]  acc_count,
  output logic              mem_enable,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              init,
  output logic              fifo_reset,
  output logic              fifo_write_enable,
  output logic              fifo_read_enable,
  output logic              fpmac_enable,
  output logic              ssd_rst,
  output logic              done,
  output logic              value_sel,
  output logic [2:0]        state_out
);

  localparam int                LCW       = cnt_width(LOAD_LEN);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MEM_DEPTH - 1);
  localparam logic [LCW-1:0]    LOAD_MAX  = LCW'(LOAD_LEN);
  localparam logic [CNT_W-1:0]  ACC_T     = CNT_W'(ACC_TARGET);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [LCW-1:0]    load_cnt_q, load_cnt_d;
  logic              init_done_q, init_done_d;
  logic              pb_q;

  logic pb_pulse;
  logic at_last;
  logic complete;
  logic load_wr;
  logic blink_phase;
  logic blink_run;

  assign pb_pulse = pb & ~pb_q;
  assign at_last  = (mem_addr_q == LAST_ADDR);
  assign complete = (acc_count == ACC_T);
  assign load_wr  = (state_q == ST_LOAD) && !fifo_full && (load_cnt_q < LOAD_MAX);

  // ---------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    mem_addr_d  = mem_addr_q;
    load_cnt_d  = load_cnt_q;
    init_done_d = init_done_q;
    case (state_q)
      ST_IDLE: begin
        mem_addr_d  = '0;
        load_cnt_d  = '0;
        init_done_d = 1'b0;
        if (pb_pulse) state_d = ST_INIT;
      end
      ST_INIT: begin
        // init_done_q marks that the last address has already had its
        // strobe; the address itself reaching the end is what unlocks pb.
        if (!at_last) mem_addr_d = mem_addr_q + ADDR_W'(1);
        else          init_done_d = 1'b1;
        if (pb_pulse && at_last) begin
          state_d    = ST_LOAD;
          mem_addr_d = '0;
          load_cnt_d = '0;
        end
      end
      ST_LOAD: begin
        if (load_wr) begin
          mem_addr_d = at_last ? '0 : mem_addr_q + ADDR_W'(1);
          load_cnt_d = load_cnt_q + LCW'(1);
        end
        if (pb_pulse) state_d = ST_MAC;
      end
      ST_MAC: begin
        if (pb_pulse) begin
          state_d    = ST_IDLE;
          mem_addr_d = '0;
          load_cnt_d = '0;
        end else if ((CONTINUOUS != 0) && complete && fifo_empty) begin
          // mem_addr is kept so the next pass reads the following block.
          state_d    = ST_LOAD;
          load_cnt_d = '0;
        end
      end
      default: begin
        state_d    = ST_IDLE;
        mem_addr_d = '0;
        load_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      mem_addr_q  <= '0;
      load_cnt_q  <= '0;
      init_done_q <= 1'b0;
      pb_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      mem_addr_q  <= mem_addr_d;
      load_cnt_q  <= load_cnt_d;
      init_done_q <= init_done_d;
      pb_q        <= pb;
    end
  end

  // ---------------------------------------------------------------------
  // Done blink while the accumulation is complete in MAC
  // ---------------------------------------------------------------------
  assign blink_run = (state_q == ST_MAC) && complete;

  blink_divider #(
    .DIV (BLINK_DIV)
  ) u_blink (
    .clk     (clock),
    .rst     (reset),
    .clr_i   (!blink_run),
    .en_i    (blink_run),
    .phase_o (blink_phase)
  );

  // ---------------------------------------------------------------------
  // Output decode. Forced low while reset is held so the FIFO and SSD
  // resets are released during board reset and reassert in IDLE after it.
  // ---------------------------------------------------------------------
  always_comb begin
    mem_enable        = 1'b0;
    init              = 1'b0;
    fifo_reset        = 1'b0;
    fifo_write_enable = 1'b0;
    fifo_read_enable  = 1'b0;
    fpmac_enable      = 1'b0;
    ssd_rst           = 1'b0;
    done              = 1'b0;
    value_sel         = 1'b0;
    if (!reset) begin
      case (state_q)
        ST_IDLE: begin
          ssd_rst    = 1'b1;
          fifo_reset = 1'b1;
        end
        ST_INIT: begin
          mem_enable = 1'b1;
          init       = !init_done_q;
          done       = at_last;
        end
        ST_LOAD: begin
          mem_enable        = 1'b1;
          fifo_write_enable = load_wr;
          done              = fifo_full || (load_cnt_q == LOAD_MAX);
        end
        ST_MAC: begin
          value_sel        = 1'b1;
          fifo_read_enable = !fifo_empty;
          fpmac_enable     = !fifo_empty;
          // Phase 0 of the divider is the "on" half, so done starts high.
          done             = complete && !blink_phase;
        end
        default: ;
      endcase
    end
  end

  assign mem_addr  = mem_addr_q;
  assign state_out = state_q;

endmodule

// File: tb/tb_mac_sequencer.sv
// tb_mac_sequencer
//   Directed stimulus with a cycle-tagged scoreboard of expected outputs
//   and a separate queue of expected FIFO write addresses. A monitor on
//   the falling edge pops and compares.
module tb_mac_sequencer;

  logic       clock;
  logic       reset;
  logic       pb;
  logic       fifo_full;
  logic       fifo_empty;
  logic [3:0] acc_count;
  logic       mem_enable;
  logic [3:0] mem_addr;
  logic       init;
  logic       fifo_reset;
  logic       fifo_write_enable;
  logic       fifo_read_enable;
  logic       fpmac_enable;
  logic       ssd_rst;
  logic       done;
  logic       value_sel;
  logic [2:0] state_out;

  mac_sequencer #(
    .ADDR_W     (4),
    .MEM_DEPTH  (16),
    .LOAD_LEN   (8),
    .CNT_W      (4),
    .ACC_TARGET (8),
    .BLINK_DIV  (4),
    .CONTINUOUS (1)
  ) dut (
    .clock             (clock),
    .reset             (reset),
    .pb                (pb),
    .fifo_full         (fifo_full),
    .fifo_empty        (fifo_empty),
    .acc_count         (acc_count),
    .mem_enable        (mem_enable),
    .mem_addr          (mem_addr),
    .init              (init),
    .fifo_reset        (fifo_reset),
    .fifo_write_enable (fifo_write_enable),
    .fifo_read_enable  (fifo_read_enable),
    .fpmac_enable      (fpmac_enable),
    .ssd_rst           (ssd_rst),
    .done              (done),
    .value_sel         (value_sel),
    .state_out         (state_out)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Observation vector layout:
  // [15:13] state [12:9] addr [8] mem_en [7] init [6] fifo_rst [5] wr
  // [4] rd [3] fpmac [2] ssd_rst [1] done [0] value_sel
  localparam logic [15:0] M_ALL   = 16'hFFFF;
  localparam logic [15:0] M_STATE = 16'hE000;
  localparam logic [15:0] M_ADDR  = 16'h1E00;
  localparam logic [15:0] M_DONE  = 16'h0002;

  typedef struct {
    int          cyc;
    string       name;
    logic [15:0] mask;
    logic [15:0] val;
  } exp_t;

  exp_t       exp_q[$];
  logic [3:0] wr_q[$];
  int         cyc;
  int         checks;
  int         errors;

  initial cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  function automatic logic [15:0] ov(input logic [2:0] st, input logic [3:0] a,
                                     input logic men, input logic ini, input logic frst,
                                     input logic wr, input logic rd, input logic fp,
                                     input logic ssd, input logic dn, input logic vs);
    return {st, a, men, ini, frst, wr, rd, fp, ssd, dn, vs};
  endfunction

  localparam logic [15:0] IDLE_V = 16'h0044; // fifo_reset and ssd_rst only

  task automatic push(input string name, input logic [15:0] mask, input logic [15:0] val);
    exp_t e;
    e.cyc  = cyc;
    e.name = name;
    e.mask = mask;
    e.val  = val;
    exp_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Monitor
  initial begin
    checks = 0;
    errors = 0;
    forever begin
      logic [15:0] obs;
      exp_t        e;
      logic [3:0]  a;
      @(negedge clock);
      obs = {state_out, mem_addr, mem_enable, init, fifo_reset, fifo_write_enable,
             fifo_read_enable, fpmac_enable, ssd_rst, done, value_sel};
      if (fifo_write_enable === 1'b1) begin
        checks++;
        if (wr_q.size() == 0) begin
          errors++;
          $display("FAIL wr_unexpected cyc=%0d addr=%0d required=no write", cyc, mem_addr);
        end else begin
          a = wr_q.pop_front();
          if (mem_addr !== a) begin
            errors++;
            $display("FAIL wr_addr cyc=%0d actual=%0d required=%0d", cyc, mem_addr, a);
          end else begin
            $display("write cyc=%0d addr=%0d", cyc, mem_addr);
          end
        end
      end
      while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
        e = exp_q.pop_front();
        checks++;
        if (e.cyc != cyc) begin
          errors++;
          $display("FAIL %s stale expectation cyc=%0d now=%0d", e.name, e.cyc, cyc);
        end else if ((obs & e.mask) !== (e.val & e.mask)) begin
          errors++;
          $display("FAIL %s cyc=%0d actual=%h required=%h mask=%h", e.name, cyc, obs, e.val, e.mask);
        end else begin
          $display("check %s cyc=%0d obs=%h", e.name, cyc, obs);
        end
      end
    end
  end

  // Stimulus
  initial begin
    reset      = 1'b1;
    pb         = 1'b0;
    fifo_full  = 1'b0;
    fifo_empty = 1'b1;
    acc_count  = 4'd0;

    tick(); push("rst_hold", M_ALL, 16'h0000);
    tick(); reset = 1'b0; push("rst_release", M_ALL, IDLE_V);
    tick(); pb = 1'b1;    push("idle_press", M_ALL, IDLE_V);

    // INIT: pb held for three cycles in total, a second press at addr 5.
    for (int k = 0; k < 18; k++) begin
      tick();
      pb = (k < 2) || (k == 5);
      push("init", M_ALL, ov(3'd1, (k < 15) ? 4'(k) : 4'd15, 1'b1, k <= 15,
                             1'b0, 1'b0, 1'b0, 1'b0, 1'b0, k >= 15, 1'b0));
    end
    tick(); pb = 1'b1;
    push("init_go", M_ALL, ov(3'd1, 4'd15, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));

    // LOAD: eight writes at 0..7, then done.
    for (int i = 0; i < 8; i++) wr_q.push_back(4'(i));
    for (int j = 0; j < 10; j++) begin
      tick(); pb = 1'b0;
      push("load", M_ALL, ov(3'd2, (j < 8) ? 4'(j) : 4'd8, 1'b1, 1'b0, 1'b0, j < 8,
                             1'b0, 1'b0, 1'b0, j >= 8, 1'b0));
    end
    tick(); pb = 1'b1;
    push("load_go", M_ALL, ov(3'd2, 4'd8, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));

    // MAC: acc 5,6,7 then 8 for 13 cycles; one empty cycle before complete,
    // empty again on the last complete cycle to trigger continuous mode.
    for (int m = 0; m < 16; m++) begin
      logic rd;
      logic dn;
      tick(); pb = 1'b0;
      acc_count  = (m < 3) ? 4'(5 + m) : 4'd8;
      fifo_empty = (m == 1) || (m == 15);
      rd = !fifo_empty;
      dn = (m >= 3) ? ((((m - 3) / 4) % 2) == 0) : 1'b0;
      push("mac", M_ALL, ov(3'd3, 4'd8, 1'b0, 1'b0, 1'b0, 1'b0, rd, rd, 1'b0, dn, 1'b1));
    end

    // Continuous LOAD from addr 8; FIFO fills after three writes.
    for (int i = 8; i < 11; i++) wr_q.push_back(4'(i));
    for (int l = 0; l < 5; l++) begin
      tick();
      fifo_full = (l >= 3);
      push("load2", M_ALL, ov(3'd2, 4'(8 + ((l < 3) ? l : 3)), 1'b1, 1'b0, 1'b0, l < 3,
                              1'b0, 1'b0, 1'b0, l >= 3, 1'b0));
    end

    // Reset mid-LOAD.
    tick(); reset = 1'b1; push("rst_mid", M_ALL, 16'h0000);
    tick();               push("rst_mid_hold", M_ALL, 16'h0000);
    tick(); reset = 1'b0; push("rst_after", M_ALL, IDLE_V);

    // Back to MAC, then pb and continuous-complete on the same cycle.
    tick(); pb = 1'b1; push("idle2", M_STATE, 16'h0000);
    tick(); pb = 1'b0; push("init2", M_STATE | M_ADDR, ov(3'd1, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    repeat (15) tick();
    push("init2_end", M_ALL, ov(3'd1, 4'd15, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
    tick(); fifo_full = 1'b1; pb = 1'b1;
    push("init2_go", M_STATE | M_DONE, ov(3'd1, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
    tick(); pb = 1'b0; fifo_empty = 1'b0; acc_count = 4'd0;
    push("load3_full", M_ALL, ov(3'd2, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
    tick(); pb = 1'b1; push("load3_go", M_STATE, ov(3'd2, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    tick(); pb = 1'b0;
    push("mac2", M_ALL, ov(3'd3, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1));
    tick(); pb = 1'b1; acc_count = 4'd8; fifo_empty = 1'b1;
    push("mac2_pb", M_ALL, ov(3'd3, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1));
    tick(); pb = 1'b0; push("pb_priority", M_ALL, IDLE_V);
    tick();            push("idle_stay", M_STATE, 16'h0000);

    tick();
    tick();
    checks++;
    if (exp_q.size() != 0 || wr_q.size() != 0) begin
      errors++;
      $display("FAIL leftover actual=%0d/%0d required=0/0", exp_q.size(), wr_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
